lift_row_seq: RTL and testbench
===============================

Name: lift_row_seq

Overview:
- Row sequencer that drives the 5/3 lifting datapath (add_mul_ram) and its even/odd sample RAM banks. It initiates the datapath transactions; the datapath responds to them.
- On each start it walks one row of even/odd sample pairs in two passes:
  - forward: predict pass, then update pass;
  - inverse: update pass, then predict pass.
- Each element follows the same sequence: read the self sample and two neighbours, present them to the datapath, capture the result, write it back in place.
- Symmetric extension is applied at both row ends.

Parameters:
- W, 20, sample width (signed two's complement)
- AW, 7, bank address width
- NPAIRS, 128, even/odd pairs per row (1..2^AW)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin a row; ignored while busy=1
- fwd_inv  in  1  1=forward, 0=inverse; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final write-back
- pix_addr_even  out  AW  even bank address
- pix_addr_odd  out  AW  odd bank address
- pix_dout_even  in  W  even bank read data, valid 1 cycle after address
- pix_dout_odd  in  W  odd bank read data, valid 1 cycle after address
- pix_din_even  out  W  even bank write data
- pix_din_odd  out  W  odd bank write data
- pix_we_even  out  1  even bank write enable
- pix_we_odd  out  1  odd bank write enable
- pix_left  out  W  left neighbour to datapath
- pix_right  out  W  right neighbour to datapath
- pix_sam  out  W  self sample to datapath
- pix_p  out  1  1=predict step, 0=update step
- pix_fwd_inv  out  1  latched fwd_inv
- lift_vld  out  1  operands valid (one cycle per element)
- lift_res  in  W  datapath result, valid the cycle after lift_vld

Behaviour:
- Reset values:
  - state=IDLE, k=0, pass=0;
  - busy, done, all we and lift_vld = 0;
  - all addresses and data outputs = 0;
  - pix_p=0, pix_fwd_inv=0.
- Reset mid-row: abort immediately, return to IDLE, no further writes. RAM contents are left partially lifted.
- Pass order:
  - forward: pass0 = predict (pix_p=1), pass1 = update (pix_p=0);
  - inverse: pass0 = update, pass1 = predict.
- Predict step, element k:
  - self = odd[k];
  - neighbours on even bank: left = even[k], right = even[min(k+1, NPAIRS-1)].
- Update step, element k:
  - self = even[k];
  - neighbours on odd bank: left = odd[max(k-1, 0)], right = odd[k].
- Reference arithmetic, computed by the datapath (not by this block):
  - forward predict: odd -= floor((L+R)/2);
  - forward update: even += floor((L+R+2)/4);
  - inverse steps apply the opposite sign in reverse pass order.
- FSM, 4 cycles per element:
  - IDLE: on start, latch fwd_inv, k=0, pass=0 -> RD_A.
  - RD_A: self bank addr=k; neighbour bank addr=left index.
  - RD_B: capture self dout -> pix_sam and neighbour dout -> pix_left; neighbour bank addr=right index.
  - EXEC: capture neighbour dout -> pix_right; lift_vld=1 for this cycle only.
  - WB: self bank addr=k; din=lift_res; we on the self bank only, one cycle. Then:
    - if k<NPAIRS-1: k++ -> RD_A;
    - else if pass=0: pass=1, k=0 -> RD_A;
    - else -> DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle -> IDLE.
- The idle bank (not self, not neighbour) holds address 0.
- Never more than one we active in any cycle.
- Latency from start to done = 1 + 8*NPAIRS + 1 cycles. NPAIRS=128 gives 1026.
- NPAIRS=1: all neighbour indices clamp to 0.
- start during busy: dropped; no queueing.
- start coincident with rst: rst wins.

Decomposition:
- Shared package lift_pkg holds:
  - state enum (IDLE, RD_A, RD_B, EXEC, WB, DONE);
  - step constants STEP_PREDICT=1, STEP_UPDATE=0;
  - W and AW defaults.
- One natural sub-module: lift_nbr_idx, a combinational neighbour-index generator with clamping (inputs k, pix_p; outputs left_idx, right_idx).

Test Plan:
- Forward 5/3 lifting, NPAIRS=4, even=[10,20,30,40], odd=[12,22,32,44], with a behavioural datapath and RAMs in the bench -> odd=[-3,-3,-3,4], even=[9,19,29,40]; done at cycle 34 after start.
- Inverse 5/3 lifting on that output -> banks restored exactly to even=[10,20,30,40], odd=[12,22,32,44].
- Boundary check, NPAIRS=4 -> predict k=3 shows left=right=even[3]; update k=0 shows left=right=odd[0].
- start pulsed at cycles 5 and 20 of a running row -> single done, writes count exactly 2*NPAIRS, busy continuous.
- rst asserted in the WB cycle of pass0, k=2 -> next cycle busy=0, no we thereafter, state IDLE; a fresh start then runs to a full 34-cycle completion.
- NPAIRS=1, even=[8], odd=[5], forward -> odd=5-8=-3, even=8+floor((-3-3+2)/4)=7.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and defaults for the 5/3 lifting row sequencer.
// FSM states, step encodings and default widths.
package lift_pkg;

    localparam int LIFT_W  = 20;
    localparam int LIFT_AW = 7;

    localparam logic STEP_PREDICT = 1'b1;
    localparam logic STEP_UPDATE  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WB,
        DONE
    } state_t;

endpackage

// File: rtl/lift_row_seq_nbr_idx.sv
// Neighbour index generator for one lifting element.
// Applies symmetric extension by clamping at both row ends.
module lift_nbr_idx
    import lift_pkg::*;
#(
    parameter int AW     = LIFT_AW,
    parameter int NPAIRS = 128
) (
    input  logic [AW-1:0] k,
    input  logic          pix_p,
    output logic [AW-1:0] left_idx,
    output logic [AW-1:0] right_idx
);

    localparam logic [AW-1:0] LAST = AW'(NPAIRS - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] ZERO = '0;

    // predict: even[k], even[k+1]; update: odd[k-1], odd[k]
    always_comb begin
        left_idx  = k;
        right_idx = k;
        if (pix_p == STEP_PREDICT) begin
            right_idx = (k == LAST) ? k : k + ONE;
        end else begin
            left_idx = (k == ZERO) ? k : k - ONE;
        end
    end

endmodule

// File: rtl/lift_row_seq.sv
// Row sequencer for the 5/3 lifting datapath and even/odd banks.
// Two passes per row, four cycles per element, in-place write-back.
module lift_row_seq
    import lift_pkg::*;
#(
    parameter int W      = LIFT_W,
    parameter int AW     = LIFT_AW,
    parameter int NPAIRS = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fwd_inv,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pix_addr_even,
    output logic [AW-1:0] pix_addr_odd,
    input  logic [W-1:0]  pix_dout_even,
    input  logic [W-1:0]  pix_dout_odd,
    output logic [W-1:0]  pix_din_even,
    output logic [W-1:0]  pix_din_odd,
    output logic          pix_we_even,
    output logic          pix_we_odd,
    output logic [W-1:0]  pix_left,
    output logic [W-1:0]  pix_right,
    output logic [W-1:0]  pix_sam,
    output logic          pix_p,
    output logic          pix_fwd_inv,
    output logic          lift_vld,
    input  logic [W-1:0]  lift_res
);

    localparam logic [AW-1:0] LAST = AW'(NPAIRS - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] k;
    logic          pass;
    logic          fwd_q;
    logic [W-1:0]  sam_q;
    logic [W-1:0]  left_q;
    logic [W-1:0]  right_q;
    logic [AW-1:0] left_idx;
    logic [AW-1:0] right_idx;
    logic [AW-1:0] self_a;
    logic [AW-1:0] nbr_a;
    logic          self_we;
    logic [W-1:0]  self_dout;
    logic [W-1:0]  nbr_dout;

    lift_nbr_idx #(
        .AW     (AW),
        .NPAIRS (NPAIRS)
    ) u_nbr_idx (
        .k         (k),
        .pix_p     (pix_p),
        .left_idx  (left_idx),
        .right_idx (right_idx)
    );

    // Forward runs predict then update; inverse runs them reversed.
    assign pix_p       = (pass ^ fwd_q) ? STEP_PREDICT : STEP_UPDATE;
    assign pix_fwd_inv = fwd_q;
    assign pix_sam     = sam_q;
    assign pix_left    = left_q;
    assign pix_right   = (state == EXEC) ? nbr_dout : right_q;

    assign self_dout = (pix_p == STEP_PREDICT) ? pix_dout_odd : pix_dout_even;
    assign nbr_dout  = (pix_p == STEP_PREDICT) ? pix_dout_even : pix_dout_odd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bank access; predict owns odd, update owns even
    always_comb begin
        state_nxt     = state;
        self_a        = '0;
        nbr_a         = '0;
        self_we       = 1'b0;
        lift_vld      = 1'b0;
        pix_addr_even = '0;
        pix_addr_odd  = '0;
        pix_din_even  = '0;
        pix_din_odd   = '0;
        pix_we_even   = 1'b0;
        pix_we_odd    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RD_A;
            end
            RD_A: begin
                self_a    = k;
                nbr_a     = left_idx;
                state_nxt = RD_B;
            end
            RD_B: begin
                nbr_a     = right_idx;
                state_nxt = EXEC;
            end
            EXEC: begin
                lift_vld  = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                self_a  = k;
                self_we = 1'b1;
                if (k != LAST || !pass) state_nxt = RD_A;
                else                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (pix_p == STEP_PREDICT) begin
            pix_addr_odd  = self_a;
            pix_addr_even = nbr_a;
            pix_we_odd    = self_we;
            pix_din_odd   = self_we ? lift_res : '0;
        end else begin
            pix_addr_even = self_a;
            pix_addr_odd  = nbr_a;
            pix_we_even   = self_we;
            pix_din_even  = self_we ? lift_res : '0;
        end
    end

    // Element/pass counters, operand capture and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            k       <= '0;
            pass    <= 1'b0;
            fwd_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sam_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        fwd_q <= fwd_inv;
                        k     <= '0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RD_B: begin
                    sam_q  <= self_dout;
                    left_q <= nbr_dout;
                end
                EXEC: begin
                    right_q <= nbr_dout;
                end
                WB: begin
                    if (k != LAST) begin
                        k <= k + ONE;
                    end else if (!pass) begin
                        pass <= 1'b1;
                        k    <= '0;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lift_row_seq.sv
// Directed bench for lift_row_seq with behavioural banks and datapath.
// Two instances: a 4-pair row and a single-pair row.
module tb_lift_row_seq;
    import lift_pkg::*;

    localparam int W  = 20;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    logic fwd_inv;
    logic ld;
    int   ld_e [0:3];
    int   ld_o [0:3];

    logic          start0, busy0, done0, we_e0, we_o0, p0, fi0, vld0;
    logic [AW-1:0] ae0, ao0;
    logic [W-1:0]  de0, do0, ie0, io0, l0, r0, s0, res0;
    logic [W-1:0]  mem_e0 [0:3];
    logic [W-1:0]  mem_o0 [0:3];

    logic          start1, busy1, done1, we_e1, we_o1, p1, fi1, vld1;
    logic [AW-1:0] ae1, ao1;
    logic [W-1:0]  de1, do1, ie1, io1, l1, r1, s1, res1;
    logic [W-1:0]  mem_e1, mem_o1;

    int n_checks = 0;
    int n_err    = 0;
    int opl [0:15];
    int opr [0:15];
    int wr_after_rst, busy_after_rst, st_after_rst;
    int exp_e [0:3];
    int exp_o [0:3];

    always #5 clk = ~clk;

    lift_row_seq #(.W(W), .AW(AW), .NPAIRS(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .fwd_inv(fwd_inv),
        .busy(busy0), .done(done0),
        .pix_addr_even(ae0), .pix_addr_odd(ao0),
        .pix_dout_even(de0), .pix_dout_odd(do0),
        .pix_din_even(ie0), .pix_din_odd(io0),
        .pix_we_even(we_e0), .pix_we_odd(we_o0),
        .pix_left(l0), .pix_right(r0), .pix_sam(s0),
        .pix_p(p0), .pix_fwd_inv(fi0),
        .lift_vld(vld0), .lift_res(res0)
    );

    lift_row_seq #(.W(W), .AW(AW), .NPAIRS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .fwd_inv(fwd_inv),
        .busy(busy1), .done(done1),
        .pix_addr_even(ae1), .pix_addr_odd(ao1),
        .pix_dout_even(de1), .pix_dout_odd(do1),
        .pix_din_even(ie1), .pix_din_odd(io1),
        .pix_we_even(we_e1), .pix_we_odd(we_o1),
        .pix_left(l1), .pix_right(r1), .pix_sam(s1),
        .pix_p(p1), .pix_fwd_inv(fi1),
        .lift_vld(vld1), .lift_res(res1)
    );

    function automatic logic [W-1:0] lift_f(input logic p, input logic fi,
        input logic [W-1:0] s, input logic [W-1:0] l, input logic [W-1:0] r);
        int si, li, ri, res;
        si = $signed(s);
        li = $signed(l);
        ri = $signed(r);
        if (p) res = fi ? si - ((li + ri) >>> 1) : si + ((li + ri) >>> 1);
        else   res = fi ? si + ((li + ri + 2) >>> 2) : si - ((li + ri + 2) >>> 2);
        return res[W-1:0];
    endfunction

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++) begin
                mem_e0[i] <= W'(ld_e[i]);
                mem_o0[i] <= W'(ld_o[i]);
            end
            mem_e1 <= W'(ld_e[0]);
            mem_o1 <= W'(ld_o[0]);
        end else begin
            if (we_e0) mem_e0[ae0[1:0]] <= ie0;
            if (we_o0) mem_o0[ao0[1:0]] <= io0;
            if (we_e1) mem_e1 <= ie1;
            if (we_o1) mem_o1 <= io1;
        end
        de0 <= mem_e0[ae0[1:0]];
        do0 <= mem_o0[ao0[1:0]];
        de1 <= mem_e1;
        do1 <= mem_o1;
        if (vld0) res0 <= lift_f(p0, fi0, s0, l0, r0);
        if (vld1) res1 <= lift_f(p1, fi1, s1, l1, r1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_row(input bit sel, input logic fi, input bit extra,
        input int rst_at, output int done_cyc, output int ndone,
        output int nwr, output int nbusy, output int nviol);
        int  nv;
        bit  rst_seen;
        logic b, d, we_e, we_o, v;
        done_cyc = 0; ndone = 0; nwr = 0; nbusy = 0; nviol = 0;
        nv = 0; rst_seen = 0;
        wr_after_rst = 0; busy_after_rst = -1; st_after_rst = -1;
        fwd_inv = fi;
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
            if (rst_seen && rst) begin
                rst = 1'b0;
                busy_after_rst = int'(busy0);
                st_after_rst   = int'(dut0.state);
            end else if (rst_seen && (we_e0 || we_o0)) begin
                wr_after_rst++;
            end
            if (extra && (cyc == 5 || cyc == 20)) begin
                if (sel) start1 = 1'b1;
                else     start0 = 1'b1;
            end
            b    = sel ? busy1 : busy0;
            d    = sel ? done1 : done0;
            we_e = sel ? we_e1 : we_e0;
            we_o = sel ? we_o1 : we_o0;
            v    = sel ? vld1 : vld0;
            if (b) nbusy++;
            if (d) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (we_e && we_o) nviol++;
            if (we_e || we_o) begin
                if (nwr == rst_at) begin
                    rst = 1'b1;
                    rst_seen = 1;
                end
                nwr++;
            end
            if (v) begin
                if (nv < 16) begin
                    opl[nv] = $signed(sel ? l1 : l0);
                    opr[nv] = $signed(sel ? r1 : r0);
                end
                nv++;
            end
        end
    endtask

    task automatic load_row();
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    initial begin
        int dc, nd, nw, nb, nvi;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        fwd_inv = 1'b0; ld = 1'b0;
        ld_e = '{10, 20, 30, 40};
        ld_o = '{12, 22, 32, 44};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_we", int'({we_e0, we_o0, vld0}), 0);
        check("rst_addr", int'({ae0, ao0}), 0);
        check("rst_data", int'(ie0 | io0 | l0 | r0 | s0), 0);
        check("rst_p_fi", int'({p0, fi0}), 0);
        rst = 1'b0;
        load_row();

        run_row(0, 1'b1, 0, -1, dc, nd, nw, nb, nvi);
        check("fwd_done_cyc", dc, 34);
        check("fwd_ndone", nd, 1);
        check("fwd_writes", nw, 8);
        check("fwd_busy_cycles", nb, 33);
        check("fwd_we_onehot", nvi, 0);
        check("bnd_pred_left", opl[3], 40);
        check("bnd_pred_right", opr[3], 40);
        check("bnd_upd_left", opl[4], -3);
        check("bnd_upd_right", opr[4], -3);
        exp_e = '{9, 19, 29, 40};
        exp_o = '{-3, -3, -3, 4};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fwd_even%0d", i), $signed(mem_e0[i]), exp_e[i]);
            check($sformatf("fwd_odd%0d", i), $signed(mem_o0[i]), exp_o[i]);
        end

        run_row(0, 1'b0, 0, -1, dc, nd, nw, nb, nvi);
        check("inv_done_cyc", dc, 34);
        check("inv_fwd_inv", int'(fi0), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("inv_even%0d", i), $signed(mem_e0[i]), ld_e[i]);
            check($sformatf("inv_odd%0d", i), $signed(mem_o0[i]), ld_o[i]);
        end

        run_row(0, 1'b1, 1, -1, dc, nd, nw, nb, nvi);
        check("busy_start_ndone", nd, 1);
        check("busy_start_writes", nw, 8);
        check("busy_start_busy", nb, 33);
        check("busy_start_done_cyc", dc, 34);

        run_row(0, 1'b1, 0, 2, dc, nd, nw, nb, nvi);
        check("rst_mid_busy", busy_after_rst, 0);
        check("rst_mid_state", st_after_rst, int'(IDLE));
        check("rst_mid_no_we", wr_after_rst, 0);
        check("rst_mid_ndone", nd, 0);
        check("rst_mid_busy_cycles", nb, 12);

        run_row(0, 1'b1, 0, -1, dc, nd, nw, nb, nvi);
        check("fresh_done_cyc", dc, 34);
        check("fresh_writes", nw, 8);
        check("fresh_ndone", nd, 1);

        ld_e[0] = 8;
        ld_o[0] = 5;
        load_row();
        run_row(1, 1'b1, 0, -1, dc, nd, nw, nb, nvi);
        check("n1_done_cyc", dc, 10);
        check("n1_writes", nw, 2);
        check("n1_odd", $signed(mem_o1), -3);
        check("n1_even", $signed(mem_e1), 7);
        check("n1_pred_left", opl[0], 8);
        check("n1_pred_right", opr[0], 8);
        check("n1_upd_left", opl[1], -3);
        check("n1_upd_right", opr[1], -3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
